aes_mm_bridge: RTL and testbench
================================

Name: aes_mm_bridge

Overview:
- Parametrised successor to the single-block AES slave interface.
- Two Avalon-MM-style slave ports: write port packs 32-bit words into 128-bit plaintext blocks; read port unpacks 128-bit result blocks into 32-bit words.
- Buffers multiple blocks in each direction (input FIFO, output FIFO) instead of one block, and adds flush, sticky overflow, status/count registers and an interrupt.
- Sits between the system bus and the AES core, which attaches through 128-bit valid/ready streams.

Parameters:
- IN_DEPTH, 8, input FIFO depth in 128-bit blocks (power of 2, >=2).
- OUT_DEPTH, 8, output FIFO depth in 128-bit blocks (power of 2, >=2).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- chipselect  in  1  write-port select.
- address  in  4  write-port word address.
- writedata  in  32  write data.
- write  in  1  write strobe; qualified by chipselect.
- chipselect1  in  1  read-port select.
- address1  in  4  read-port word address.
- read  in  1  read strobe; qualified by chipselect1.
- readdata  out  32  read data; valid in any cycle where read is accepted.
- waitrequest  out  1  read-port stall.
- blk_in_data  out  128  plaintext block to the core.
- blk_in_valid  out  1  block available to the core.
- blk_in_ready  in  1  core accepts the block.
- blk_out_data  in  128  result block from the core.
- blk_out_valid  in  1  core result valid.
- blk_out_ready  out  1  bridge can accept a result.
- irq  out  1  level interrupt.

Behaviour:
- Reset values (async, resetn=0): readdata=0, waitrequest=0, blk_in_valid=0, blk_out_ready=1, irq=0. Both FIFOs empty; packer/unpacker word indices=0; overflow=0; irq_en=0; blk_cnt=0.
- Write map:
  - 0x0 DATA_IN: packer word.
  - 0x1 CTRL: bit0 flush, self-clearing; bit1 irq_en.
  - 0x2 CLR: bit0 clears overflow.
  - All other addresses: ignored.
- Read map:
  - 0x4 DATA_OUT.
  - 0x5 STATUS: [7:0] in_count, [15:8] out_count, bit16 in_full, bit17 out_empty, bit18 overflow, bit19 irq_en.
  - 0x6 BLK_CNT: zero-extended.
  - All other addresses: 0.
- Packer:
  - Word 0 fills [127:96], word 3 fills [31:0]. Index wraps 3->0.
  - On the 4th accepted write, the block is pushed at that clock edge. blk_in_valid is high from the following cycle.
  - If the input FIFO is full at the 4th write: block dropped, overflow set (sticky), index still wraps to 0.
- Core in: blk_in_valid = !in_empty; blk_in_data = FIFO head. Pop on valid&&ready.
- Core out: blk_out_ready = !out_full. Push on valid&&ready; blk_cnt increments (wraps modulo 2^CNT_W).
- Unpacker:
  - DATA_OUT read when out_empty: waitrequest=1 (combinational) until a block exists. Master holds read and address1.
  - When not empty: waitrequest=0 and readdata = head word[index], index 0 = [127:96] (zero-latency read).
  - Index advances at an accepted-read edge. After word 3 the head is popped and index returns to 0.
  - STATUS/BLK_CNT reads never wait.
- Same-cycle push and pop on either FIFO: both occur; count unchanged.
- Full FIFO with simultaneous pop: push is accepted.
- Flush:
  - Clears both FIFOs and both word indices next edge; flush wins over any same-cycle push, pop or packer write.
  - overflow, irq_en and blk_cnt are preserved.
  - A pending stalled DATA_OUT read keeps waiting.
  - Blocks in flight inside the core are not cancelled and land in the emptied output FIFO.
- irq: registered; irq = irq_en && !out_empty, updated every edge.
- Reset mid-operation: immediate return to the reset state; partial blocks are lost.
- Write port and read port operate independently in the same cycle.

Decomposition:
- Package aes_intf_pkg holds:
  - BLOCK_W=128, WORD_W=32.
  - Address constants ADDR_DATA_IN, ADDR_CTRL, ADDR_CLR, ADDR_DATA_OUT, ADDR_STATUS, ADDR_BLK_CNT.
  - STATUS bit-position constants and CTRL bit constants.
- Sub-module aes_blk_fifo (params DEPTH, WIDTH):
  - Ports: push, pop, flush, din, dout (head, combinational), full, empty, count.
  - Instantiated twice.
- Top holds the packer, unpacker, register decode and irq.

Test Plan:
- Reset -> STATUS read = 0x00020000 (out_empty=1, counts 0); irq=0; blk_out_ready=1; blk_in_valid=0.
- Write 0xffeeddcc, 0xbbaa9988, 0x77665544, 0x33221100 to 0x0 -> one cycle later blk_in_valid=1 and blk_in_data=128'hffeeddccbbaa99887766554433221100.
- Core model returns 128'hf47237c18b4c5a4059d1c3ab48966732 -> four 0x4 reads return f47237c1, 8b4c5a40, 59d1c3ab, 48966732; BLK_CNT=1; out_empty=1 afterwards.
- DATA_OUT read held while the output is empty -> waitrequest=1 for every cycle until the core pushes; first word appears in the cycle waitrequest drops.
- blk_in_ready=0, write IN_DEPTH+1 blocks -> in_full=1, overflow=1. Release ready -> exactly IN_DEPTH blocks reach the core, in order. CLR bit0 -> overflow=0.
- irq_en=1, two blocks returned, then flush via CTRL during packing (2 words written) -> irq falls next edge, counts=0; the next 4 writes form a clean block starting at [127:96].

Source files
------------

// File: rtl/aes_intf_pkg.sv
// ============================================================================
// Module      : aes_intf_pkg
// Description : Shared widths, register map and helpers for the AES MM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_intf_pkg;

   localparam int BLOCK_W = 128;
   localparam int WORD_W  = 32;
   localparam int WORDS   = BLOCK_W / WORD_W;

   localparam logic [3:0] ADDR_DATA_IN  = 4'h0;
   localparam logic [3:0] ADDR_CTRL     = 4'h1;
   localparam logic [3:0] ADDR_CLR      = 4'h2;
   localparam logic [3:0] ADDR_DATA_OUT = 4'h4;
   localparam logic [3:0] ADDR_STATUS   = 4'h5;
   localparam logic [3:0] ADDR_BLK_CNT  = 4'h6;

   localparam int CTRL_FLUSH_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CLR_OVF_BIT     = 0;

   localparam int ST_IN_CNT_LSB  = 0;
   localparam int ST_OUT_CNT_LSB = 8;
   localparam int ST_IN_FULL     = 16;
   localparam int ST_OUT_EMPTY   = 17;
   localparam int ST_OVERFLOW    = 18;
   localparam int ST_IRQ_EN      = 19;

   // Word 0 is the most significant word of a block.
   function automatic logic [WORD_W-1:0] blk_word(input logic [BLOCK_W-1:0] blk,
                                                  input logic [1:0]         idx);
      return blk[(WORDS - 1 - int'(idx)) * WORD_W +: WORD_W];
   endfunction

endpackage

`default_nettype wire

// File: rtl/aes_blk_fifo.sv
// ============================================================================
// Module      : aes_blk_fifo
// Description : Block FIFO with combinational head, flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_blk_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 128
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == C_FULL);
   assign count = r_count;
   assign dout  = r_mem[r_rptr];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/aes_mm_bridge.sv
// ============================================================================
// Module      : aes_mm_bridge
// Description : Avalon-MM word packer/unpacker with block FIFOs for an AES core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mm_bridge
   import aes_intf_pkg::*;
#(
   parameter int IN_DEPTH  = 8,
   parameter int OUT_DEPTH = 8,
   parameter int CNT_W     = 16
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               chipselect,
   input  logic [3:0]         address,
   input  logic [WORD_W-1:0]  writedata,
   input  logic               write,
   input  logic               chipselect1,
   input  logic [3:0]         address1,
   input  logic               read,
   output logic [WORD_W-1:0]  readdata,
   output logic               waitrequest,
   output logic [BLOCK_W-1:0] blk_in_data,
   output logic               blk_in_valid,
   input  logic               blk_in_ready,
   input  logic [BLOCK_W-1:0] blk_out_data,
   input  logic               blk_out_valid,
   output logic               blk_out_ready,
   output logic               irq
);

   localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
   localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

   logic [IN_CW-1:0]    w_in_count;
   logic [OUT_CW-1:0]   w_out_count;
   logic                w_in_full, w_in_empty, w_out_full, w_out_empty;
   logic [BLOCK_W-1:0]  w_out_head;
   logic                w_wr, w_wr_data, w_wr_ctrl, w_wr_clr, w_flush;
   logic                w_pack_push, w_in_pop;
   logic                w_rd, w_rd_data, w_rd_data_acc, w_out_pop, w_out_push;
   logic [WORD_W-1:0]   w_status;

   logic [3*WORD_W-1:0] r_pack;
   logic [1:0]          r_widx;
   logic [1:0]          r_ridx;
   logic                r_ovf;
   logic                r_irq_en;
   logic [CNT_W-1:0]    r_blk_cnt;
   logic                r_irq;

   assign w_wr          = chipselect && write;
   assign w_wr_data     = w_wr && (address == ADDR_DATA_IN);
   assign w_wr_ctrl     = w_wr && (address == ADDR_CTRL);
   assign w_wr_clr      = w_wr && (address == ADDR_CLR);
   assign w_flush       = w_wr_ctrl && writedata[CTRL_FLUSH_BIT];
   assign w_pack_push   = w_wr_data && (r_widx == 2'd3);
   assign w_in_pop      = !w_in_empty && blk_in_ready;

   assign w_rd          = chipselect1 && read;
   assign w_rd_data     = w_rd && (address1 == ADDR_DATA_OUT);
   assign w_rd_data_acc = w_rd_data && !w_out_empty;
   assign w_out_pop     = w_rd_data_acc && (r_ridx == 2'd3);
   assign w_out_push    = blk_out_valid && !w_out_full;

   assign blk_in_valid  = !w_in_empty;
   assign blk_out_ready = !w_out_full;
   assign waitrequest   = w_rd_data && w_out_empty;
   assign irq           = r_irq;

   aes_blk_fifo #(.DEPTH(IN_DEPTH), .WIDTH(BLOCK_W)) u_in_fifo (
      .clk   (clock),
      .rst_n (resetn),
      .push  (w_pack_push),
      .pop   (w_in_pop),
      .flush (w_flush),
      .din   ({r_pack, writedata}),
      .dout  (blk_in_data),
      .full  (w_in_full),
      .empty (w_in_empty),
      .count (w_in_count)
   );

   aes_blk_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(BLOCK_W)) u_out_fifo (
      .clk   (clock),
      .rst_n (resetn),
      .push  (w_out_push),
      .pop   (w_out_pop),
      .flush (w_flush),
      .din   (blk_out_data),
      .dout  (w_out_head),
      .full  (w_out_full),
      .empty (w_out_empty),
      .count (w_out_count)
   );

   always_comb begin
      w_status                            = '0;
      w_status[ST_IN_CNT_LSB +: 8]        = 8'(w_in_count);
      w_status[ST_OUT_CNT_LSB +: 8]       = 8'(w_out_count);
      w_status[ST_IN_FULL]                = w_in_full;
      w_status[ST_OUT_EMPTY]              = w_out_empty;
      w_status[ST_OVERFLOW]               = r_ovf;
      w_status[ST_IRQ_EN]                 = r_irq_en;
   end

   // Zero-latency read mux; idle bus reads back as zero.
   always_comb begin
      readdata = '0;
      if (w_rd) begin
         case (address1)
            ADDR_DATA_OUT: if (!w_out_empty) readdata = blk_word(w_out_head, r_ridx);
            ADDR_STATUS:   readdata = w_status;
            ADDR_BLK_CNT:  readdata = WORD_W'(r_blk_cnt);
            default:       readdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pack    <= '0;
         r_widx    <= '0;
         r_ridx    <= '0;
         r_ovf     <= 1'b0;
         r_irq_en  <= 1'b0;
         r_blk_cnt <= '0;
         r_irq     <= 1'b0;
      end else begin
         if (w_wr_data) begin
            r_pack <= {r_pack[2*WORD_W-1:0], writedata};
            r_widx <= r_widx + 2'd1;
         end
         if (w_rd_data_acc) r_ridx <= r_ridx + 2'd1;
         if (w_flush) begin
            r_widx <= '0;
            r_ridx <= '0;
         end
         // A 4th word arriving at a full FIFO with no departing head is lost.
         if (w_pack_push && w_in_full && !w_in_pop)
            r_ovf <= 1'b1;
         else if (w_wr_clr && writedata[CLR_OVF_BIT])
            r_ovf <= 1'b0;
         if (w_wr_ctrl)  r_irq_en  <= writedata[CTRL_IRQ_EN_BIT];
         if (w_out_push) r_blk_cnt <= r_blk_cnt + CNT_W'(1);
         r_irq <= r_irq_en && !w_out_empty;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_aes_mm_bridge.sv
// ============================================================================
// Module      : tb_aes_mm_bridge
// Description : Scoreboard testbench for aes_mm_bridge with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_mm_bridge;
   import aes_intf_pkg::*;

   localparam int IN_DEPTH  = 8;
   localparam int OUT_DEPTH = 8;
   localparam int CNT_W     = 16;

   logic         clock = 1'b0;
   logic         resetn = 1'b0;
   logic         chipselect = 1'b0, write = 1'b0;
   logic [3:0]   address = '0;
   logic [31:0]  writedata = '0;
   logic         chipselect1 = 1'b0, read = 1'b0;
   logic [3:0]   address1 = '0;
   logic [31:0]  readdata;
   logic         waitrequest;
   logic [127:0] blk_in_data;
   logic         blk_in_valid;
   logic         blk_in_ready = 1'b0;
   logic [127:0] blk_out_data = '0;
   logic         blk_out_valid = 1'b0;
   logic         blk_out_ready;
   logic         irq;

   int checks = 0;
   int passes = 0;
   logic [31:0]  exp_rd[$];
   logic [127:0] exp_blk[$];

   aes_mm_bridge #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .resetn(resetn),
      .chipselect(chipselect), .address(address), .writedata(writedata), .write(write),
      .chipselect1(chipselect1), .address1(address1), .read(read),
      .readdata(readdata), .waitrequest(waitrequest),
      .blk_in_data(blk_in_data), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready),
      .blk_out_data(blk_out_data), .blk_out_valid(blk_out_valid), .blk_out_ready(blk_out_ready),
      .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Read-port monitor: every accepted read is scored against the queue.
   always @(negedge clock) begin
      if (resetn && chipselect1 && read && !waitrequest) begin
         if (exp_rd.size() == 0) begin
            checks++;
            $display("FAIL rd_unexpected: got %h expected no read", readdata);
         end else
            check("readdata", 128'(readdata), 128'(exp_rd.pop_front()));
      end
   end

   // Core-side monitor: every block handed to the core is scored in order.
   always @(negedge clock) begin
      if (resetn && blk_in_valid && blk_in_ready) begin
         if (exp_blk.size() == 0) begin
            checks++;
            $display("FAIL blk_unexpected: got %h expected no block", blk_in_data);
         end else
            check("blk_in_data", blk_in_data, exp_blk.pop_front());
      end
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(posedge clock); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic wr_blk(input logic [127:0] b);
      for (int k = 0; k < 4; k++) wr(ADDR_DATA_IN, b[(3-k)*32 +: 32]);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, output int stalls);
      exp_rd.push_back(exp);
      chipselect1 = 1'b1; read = 1'b1; address1 = a; stalls = 0;
      @(negedge clock);
      while (waitrequest && stalls < 50) begin
         stalls++;
         @(negedge clock);
      end
      if (waitrequest) begin
         checks++;
         $display("FAIL rd_timeout: got waitrequest=1 expected 0 within 50 cycles");
         void'(exp_rd.pop_back());
      end
      @(posedge clock); #1;
      chipselect1 = 1'b0; read = 1'b0;
   endtask

   task automatic rdc(input logic [3:0] a, input logic [31:0] exp);
      int s;
      rd(a, exp, s);
   endtask

   task automatic core_ret(input logic [127:0] d);
      int n = 0;
      blk_out_valid = 1'b1; blk_out_data = d;
      @(negedge clock);
      while (!blk_out_ready && n < 50) begin n++; @(negedge clock); end
      if (!blk_out_ready) begin
         checks++;
         $display("FAIL core_ret_timeout: got blk_out_ready=0 expected 1");
      end
      @(posedge clock); #1;
      blk_out_valid = 1'b0;
   endtask

   task automatic pulse_ready(input int n);
      blk_in_ready = 1'b1;
      repeat (n) @(posedge clock);
      #1;
      blk_in_ready = 1'b0;
   endtask

   function automatic logic [127:0] mk_blk(input int b);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[(3-k)*32 +: 32] = {8'(b), 8'(k), 16'hA5C3};
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      logic [127:0] blk_a, blk_r, blk_s;
      blk_a = 128'hffeeddccbbaa99887766554433221100;
      blk_r = 128'hf47237c18b4c5a4059d1c3ab48966732;
      blk_s = 128'h0a0b0c0d1a1b1c1d2a2b2c2d3a3b3c3d;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_irq", 128'(irq), 128'd0);
      check("rst_blk_out_ready", 128'(blk_out_ready), 128'd1);
      check("rst_blk_in_valid", 128'(blk_in_valid), 128'd0);
      check("rst_waitrequest", 128'(waitrequest), 128'd0);
      check("rst_readdata", 128'(readdata), 128'd0);
      resetn = 1'b1;
      @(posedge clock); #1;
      rdc(ADDR_STATUS, 32'h0002_0000);

      // Packer: block visible from the cycle after the 4th write
      wr(ADDR_DATA_IN, 32'hffeeddcc);
      wr(ADDR_DATA_IN, 32'hbbaa9988);
      wr(ADDR_DATA_IN, 32'h77665544);
      check("valid_before_4th", 128'(blk_in_valid), 128'd0);
      exp_blk.push_back(blk_a);
      wr(ADDR_DATA_IN, 32'h33221100);
      check("valid_after_4th", 128'(blk_in_valid), 128'd1);
      rdc(ADDR_STATUS, 32'h0002_0001);
      pulse_ready(1);

      // Unpacker: result block read back word by word
      core_ret(blk_r);
      rdc(ADDR_DATA_OUT, 32'hf47237c1);
      rdc(ADDR_DATA_OUT, 32'h8b4c5a40);
      rdc(ADDR_DATA_OUT, 32'h59d1c3ab);
      rdc(ADDR_DATA_OUT, 32'h48966732);
      rdc(ADDR_BLK_CNT, 32'd1);
      rdc(ADDR_STATUS, 32'h0002_0000);

      // Stalled DATA_OUT read released by a late core push
      fork
         rd(ADDR_DATA_OUT, 32'h0a0b0c0d, s);
         begin
            repeat (5) @(posedge clock);
            #1;
            core_ret(blk_s);
         end
      join
      check("stall_cycles", 128'(s), 128'd6);
      rdc(ADDR_DATA_OUT, 32'h1a1b1c1d);
      rdc(ADDR_DATA_OUT, 32'h2a2b2c2d);
      rdc(ADDR_DATA_OUT, 32'h3a3b3c3d);
      rdc(ADDR_BLK_CNT, 32'd2);

      // Input overflow: IN_DEPTH+1 blocks with the core stalled
      for (int b = 0; b <= IN_DEPTH; b++) begin
         if (b < IN_DEPTH) exp_blk.push_back(mk_blk(b));
         wr_blk(mk_blk(b));
      end
      rdc(ADDR_STATUS, 32'h0007_0008);
      pulse_ready(IN_DEPTH + 4);
      check("drained_valid", 128'(blk_in_valid), 128'd0);
      wr(ADDR_CLR, 32'h1);
      rdc(ADDR_STATUS, 32'h0002_0000);

      // irq and flush during packing
      wr(ADDR_CTRL, 32'h2);
      core_ret(128'h1);
      core_ret(128'h2);
      @(posedge clock); #1;
      check("irq_raised", 128'(irq), 128'd1);
      rdc(ADDR_STATUS, 32'h0008_0200);
      wr(ADDR_DATA_IN, 32'hdeadbeef);
      wr(ADDR_DATA_IN, 32'hcafef00d);
      wr(ADDR_CTRL, 32'h3);
      @(posedge clock); #1;
      check("irq_after_flush", 128'(irq), 128'd0);
      rdc(ADDR_STATUS, 32'h000A_0000);
      exp_blk.push_back(128'h11111111_22222222_33333333_44444444);
      wr_blk(128'h11111111_22222222_33333333_44444444);
      pulse_ready(2);
      rdc(ADDR_BLK_CNT, 32'd4);
      rdc(4'h7, 32'h0);

      check("blk_queue_drained", 128'(exp_blk.size()), 128'd0);
      check("rd_queue_drained", 128'(exp_rd.size()), 128'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
